word_tx_ctrl: RTL and testbench
===============================

# word_tx_ctrl

Serialises a 32-bit word into four bytes, least-significant byte first, and hands each byte to the UART transmitter over a byte strobe/busy handshake. It is the transmit-side counterpart of the 4-byte word assembler on the receive path. It sits between the measurement/control logic and the UART tx core, so a word assembled on the far end matches the word presented here.

## Interface
- HDR_BYTE, 8'hA5, sync byte sent before the word when FRAME_HDR_EN is defined
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- tx_word  input  32  word to send; sampled only on an accepted tx_start
- tx_start  input  1  one-cycle request to send tx_word
- tx_busy  input  1  from UART tx; high while a byte is being shifted out
- tx_data  output  8  byte to UART tx; valid in the tx_en cycle
- tx_en  output  1  one-cycle strobe; UART tx captures tx_data on it
- busy  output  1  high from the accepted start through DONE
- tx_done  output  1  one-cycle pulse after the last byte completes

## Operation
- States: IDLE, ISSUE, HOLD, WAIT, DONE. Byte index idx is 2 bits; 3 bits with FRAME_HDR_EN.
- IDLE
  - busy=0.
  - If tx_start=1, latch tx_word into word_r, clear idx, go to ISSUE.
  - tx_start is ignored in every other state; no queuing.
- ISSUE
  - If tx_busy=0: drive tx_data=word_r[8*idx+7 : 8*idx], pulse tx_en for one cycle, go to HOLD.
  - If tx_busy=1: stay in ISSUE with tx_en=0.
- HOLD
  - Unconditional one-cycle gap so the UART can raise tx_busy. Go to WAIT.
- WAIT
  - Stay while tx_busy=1.
  - When tx_busy=0 and idx is the last index, go to DONE.
  - When tx_busy=0 otherwise, increment idx and go to ISSUE.
- DONE
  - Pulse tx_done for one cycle, go to IDLE.
- Byte order is fixed: word_r[7:0], [15:8], [23:16], [31:24].
- tx_data keeps its last driven value between strobes; only tx_en qualifies it.
- Reset, including in the middle of a frame
  - Next state is IDLE; tx_en=0, tx_done=0, busy=0, tx_data=8'h00, word_r=0, idx=0.
  - A partially sent frame is abandoned and no tx_done is issued.
- Changes to tx_word after acceptance have no effect on the frame in flight.

## Timing
- Reset values: tx_data=8'h00, tx_en=0, busy=0, tx_done=0.
- Start latency: tx_start in cycle T gives the first tx_en in cycle T+1 if tx_busy=0.
- Per byte, with an ideal sink (tx_busy never asserted): ISSUE, HOLD, WAIT = 3 cycles.
  - Frame: 12 cycles from first tx_en to tx_done for 4 bytes.
  - Frame: 15 cycles with the header.
- With a real UART, each byte occupies 2 cycles + the tx_busy high time + 1 cycle.
- tx_en is never asserted in a cycle where tx_busy=1.
- tx_en is never asserted on two consecutive cycles.
- tx_start in the same cycle as tx_done is ignored. A new frame can be accepted one cycle later, in IDLE.
- busy rises in the cycle after the accepted tx_start and falls in the cycle after tx_done.

## Configuration
- FRAME_HDR_EN defined
  - HDR_BYTE is sent first at idx 0; word bytes follow at idx 1..4.
  - Frame is 5 bytes.
- FRAME_HDR_EN undefined
  - No header logic and no HDR_BYTE use.
  - Frame is exactly the 4 word bytes, byte-compatible with the receive-side assembler.

## Test plan
- Ideal sink, tx_word=32'h12345678, tx_start pulse
  - tx_en strobes carry 78, 56, 34, 12, spaced 3 cycles apart.
  - tx_done arrives 3 cycles after the last strobe.
- UART model holding tx_busy high for 10 cycles per byte, tx_word=32'hDEADBEEF
  - Bytes EF, BE, AD, DE.
  - No tx_en while tx_busy=1; busy stays high for the whole frame.
- tx_busy=1 at start for 5 cycles
  - First tx_en is delayed until the cycle tx_busy falls.
- Second tx_start with 32'hFFFFFFFF mid-frame, and tx_word changed mid-frame
  - Original 32'h12345678 bytes complete unchanged; the second request is dropped.
- rst=0 for one cycle after the second byte, then a new start with 32'h00000001
  - Outputs return to reset values and no tx_done is issued.
  - New frame sends 01, 00, 00, 00.
- FRAME_HDR_EN defined, tx_word=32'h12345678
  - Strobes carry A5, 78, 56, 34, 12; tx_done 15 cycles after the first strobe with an ideal sink.

Source files
------------

// File: rtl/word_tx_ctrl.sv
// word_tx_ctrl: serialises a 32-bit word LSB-first onto a byte strobe/busy UART tx link.
// Define FRAME_HDR_EN to prefix each frame with the 8'hA5 sync byte.
module word_tx_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_word,
    input  logic        tx_start,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        busy,
    output logic        tx_done
);

`ifdef FRAME_HDR_EN
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = 3'd4;
`else
    localparam int IDX_W = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [31:0]        word_r;
    logic [31:0]        word_nx;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nx;
    logic [7:0]         last_r;
    logic [7:0]         cur_byte;
    logic               en_c;

    always_comb begin
        cur_byte = 8'h00;
`ifdef FRAME_HDR_EN
        unique case (idx)
            3'd0:    cur_byte = HDR_BYTE;
            3'd1:    cur_byte = word_r[7:0];
            3'd2:    cur_byte = word_r[15:8];
            3'd3:    cur_byte = word_r[23:16];
            3'd4:    cur_byte = word_r[31:24];
            default: cur_byte = 8'h00;
        endcase
`else
        unique case (idx)
            2'd0: cur_byte = word_r[7:0];
            2'd1: cur_byte = word_r[15:8];
            2'd2: cur_byte = word_r[23:16];
            2'd3: cur_byte = word_r[31:24];
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            word_r <= '0;
            idx    <= '0;
            last_r <= 8'h00;
        end else begin
            state  <= state_nx;
            word_r <= word_nx;
            idx    <= idx_nx;
            if (en_c)
                last_r <= cur_byte;
        end
    end

    always_comb begin
        state_nx = state;
        word_nx  = word_r;
        idx_nx   = idx;
        en_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_start) begin
                    word_nx  = tx_word;
                    idx_nx   = '0;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!tx_busy) begin
                    en_c     = 1'b1;
                    state_nx = HOLD;
                end
            end
            // gap cycle lets the UART raise tx_busy before we look at it
            HOLD: state_nx = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    if (idx == LAST_IDX) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        state_nx = ISSUE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs forced to their reset values while rst is held low
    assign tx_en   = rst & en_c;
    assign tx_done = rst & (state == DONE);
    assign busy    = rst & (state != IDLE);
    assign tx_data = !rst ? 8'h00 : (en_c ? cur_byte : last_r);

endmodule

// File: tb/tb_word_tx_ctrl.sv
// tb_word_tx_ctrl: randomized self-checking bench for word_tx_ctrl.
// Expected bytes come from a queue model of the frame layout.
module tb_word_tx_ctrl;

`ifdef FRAME_HDR_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tx_word = '0;
    logic        tx_start = 1'b0;
    logic        force_busy = 1'b0;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        busy;
    logic        tx_done;

    int cyc = 0;
    int ucnt = 0;
    int uart_len = 0;
    int checks = 0;
    int failures = 0;
    int start_cyc = 0;
    int busy_drop = 0;
    bit prev_en = 1'b0;
    bit frame_active = 1'b0;

    logic [7:0] en_q[$];
    int         en_t[$];
    int         done_t[$];
    logic [7:0] exp_q[$];

    word_tx_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tx_word  (tx_word),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    assign tx_busy = force_busy | (ucnt != 0);

    // UART model: busy for uart_len cycles after each captured strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_len > 0 && tx_en)
            ucnt <= uart_len;
        else if (ucnt > 0)
            ucnt <= ucnt - 1;
    end

    always @(negedge clk) begin
        if (tx_en) begin
            en_q.push_back(tx_data);
            en_t.push_back(cyc);
            checks++;
            if (tx_busy) begin
                failures++;
                $display("FAIL en_while_busy cyc=%0d tx_busy=%b required=0", cyc, tx_busy);
            end
            checks++;
            if (prev_en) begin
                failures++;
                $display("FAIL en_back_to_back cyc=%0d prev_en=%b required=0", cyc, prev_en);
            end
        end
        prev_en = tx_en;
        if (tx_done)
            done_t.push_back(cyc);
        if (frame_active && !busy)
            busy_drop++;
    end

    function automatic void model(input logic [31:0] w);
`ifdef FRAME_HDR_EN
        exp_q.push_back(8'hA5);
`endif
        for (int i = 0; i < 4; i++)
            exp_q.push_back(w[8*i +: 8]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        en_q.delete();
        en_t.delete();
        done_t.delete();
        exp_q.delete();
        busy_drop = 0;
    endtask

    task automatic send(input logic [31:0] w);
        tx_word   = w;
        tx_start  = 1'b1;
        start_cyc = cyc;
        tick();
        tx_start  = 1'b0;
        frame_active = 1'b1;
    endtask

    task automatic wait_done(input int budget, input int want);
        int n = 0;
        while (done_t.size() < want && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        frame_active = 1'b0;
        checks++;
        if (done_t.size() < want) begin
            failures++;
            $display("FAIL done_timeout got=%0d done pulses required=%0d", done_t.size(), want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (tx_data !== 8'h00) begin
            failures++;
            $display("FAIL rst_tx_data got=%h required=00", tx_data);
        end
        checks++;
        if (tx_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_tx_en got=%b required=0", tx_en);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got=%b required=0", busy);
        end
        checks++;
        if (tx_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_tx_done got=%b required=0", tx_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ideal();
        clear();
        send(32'h12345678);
        wait_done(60, 1);
        model(32'h12345678);
        checks++;
        if (en_q.size() != NB) begin
            failures++;
            $display("FAIL ideal_count got=%0d required=%0d", en_q.size(), NB);
        end
        for (int i = 0; i < NB && i < en_q.size(); i++) begin
            checks++;
            if (en_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL ideal_byte%0d got=%h required=%h", i, en_q[i], exp_q[i]);
            end
        end
        if (en_t.size() == NB && done_t.size() == 1) begin
            checks++;
            if (en_t[0] != start_cyc + 1) begin
                failures++;
                $display("FAIL ideal_latency got=%0d required=%0d", en_t[0] - start_cyc, 1);
            end
            for (int i = 1; i < NB; i++) begin
                checks++;
                if (en_t[i] - en_t[i-1] != 3) begin
                    failures++;
                    $display("FAIL ideal_spacing%0d got=%0d required=3", i, en_t[i] - en_t[i-1]);
                end
            end
            checks++;
            if (done_t[0] - en_t[NB-1] != 3) begin
                failures++;
                $display("FAIL ideal_done_gap got=%0d required=3", done_t[0] - en_t[NB-1]);
            end
            checks++;
            if (done_t[0] - en_t[0] != 3 * NB) begin
                failures++;
                $display("FAIL ideal_frame_len got=%0d required=%0d", done_t[0] - en_t[0], 3 * NB);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ideal_busy_fall got=%b required=0", busy);
        end
        checks++;
        if (busy_drop != 0) begin
            failures++;
            $display("FAIL ideal_busy_hold got=%0d low cycles required=0", busy_drop);
        end
        tick();
    endtask

    task automatic test_uart();
        uart_len = 10;
        clear();
        send(32'hDEADBEEF);
        wait_done(300, 1);
        uart_len = 0;
        model(32'hDEADBEEF);
        checks++;
        if (en_q.size() != NB) begin
            failures++;
            $display("FAIL uart_count got=%0d required=%0d", en_q.size(), NB);
        end
        for (int i = 0; i < NB && i < en_q.size(); i++) begin
            checks++;
            if (en_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL uart_byte%0d got=%h required=%h", i, en_q[i], exp_q[i]);
            end
        end
        checks++;
        if (busy_drop != 0) begin
            failures++;
            $display("FAIL uart_busy_hold got=%0d low cycles required=0", busy_drop);
        end
        repeat (3) tick();
    endtask

    task automatic test_busy_start();
        force_busy = 1'b1;
        clear();
        tick();
        send(32'hCAFEF00D);
        repeat (4) tick();
        force_busy = 1'b0;
        wait_done(60, 1);
        model(32'hCAFEF00D);
        checks++;
        if (en_t.size() == 0 || en_t[0] != start_cyc + 5) begin
            failures++;
            $display("FAIL busy_start_latency got=%0d required=%0d",
                     en_t.size() == 0 ? -1 : en_t[0] - start_cyc, 5);
        end
        checks++;
        if (en_q.size() != NB) begin
            failures++;
            $display("FAIL busy_start_count got=%0d required=%0d", en_q.size(), NB);
        end
        for (int i = 0; i < NB && i < en_q.size(); i++) begin
            checks++;
            if (en_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL busy_start_byte%0d got=%h required=%h", i, en_q[i], exp_q[i]);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_ignore_start();
        clear();
        send(32'h12345678);
        repeat (4) tick();
        tx_word  = 32'hFFFFFFFF;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_word  = $urandom;
        wait_done(60, 1);
        repeat (20) tick();
        model(32'h12345678);
        checks++;
        if (en_q.size() != NB) begin
            failures++;
            $display("FAIL ignore_count got=%0d required=%0d", en_q.size(), NB);
        end
        for (int i = 0; i < NB && i < en_q.size(); i++) begin
            checks++;
            if (en_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL ignore_byte%0d got=%h required=%h", i, en_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_t.size() != 1) begin
            failures++;
            $display("FAIL ignore_done_count got=%0d required=1", done_t.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1;
        logic [31:0] w2;
        int s2;
        w1 = $urandom;
        w2 = $urandom;
        clear();
        send(w1);
        wait_done(60, 1);
        tx_word  = ~w1;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_word  = w2;
        s2       = cyc;
        tick();
        tx_start = 1'b0;
        frame_active = 1'b1;
        wait_done(60, 2);
        repeat (10) tick();
        model(w1);
        model(w2);
        checks++;
        if (en_q.size() != 2 * NB) begin
            failures++;
            $display("FAIL b2b_count got=%0d required=%0d", en_q.size(), 2 * NB);
        end
        for (int i = 0; i < 2 * NB && i < en_q.size(); i++) begin
            checks++;
            if (en_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_byte%0d got=%h required=%h", i, en_q[i], exp_q[i]);
            end
        end
        checks++;
        if (en_t.size() <= NB || en_t[NB] != s2 + 1) begin
            failures++;
            $display("FAIL b2b_latency got=%0d required=1",
                     en_t.size() <= NB ? -1 : en_t[NB] - s2);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear();
        send(32'h12345678);
        while (en_q.size() < 2 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (en_q.size() < 2) begin
            failures++;
            $display("FAIL rmid_timeout got=%0d strobes required=2", en_q.size());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame_active = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_en, busy, tx_done, tx_data} !== 11'h000) begin
            failures++;
            $display("FAIL rmid_in_reset got=en%b busy%b done%b data%h required=all zero",
                     tx_en, busy, tx_done, tx_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL rmid_after_reset got=busy%b data%h required=busy0 data00", busy, tx_data);
        end
        repeat (20) tick();
        checks++;
        if (done_t.size() != 0 || en_q.size() != 2) begin
            failures++;
            $display("FAIL rmid_abandon got=done%0d strobes%0d required=done0 strobes2",
                     done_t.size(), en_q.size());
        end
        clear();
        send(32'h00000001);
        wait_done(60, 1);
        model(32'h00000001);
        checks++;
        if (en_q.size() != NB) begin
            failures++;
            $display("FAIL rmid_count got=%0d required=%0d", en_q.size(), NB);
        end
        for (int i = 0; i < NB && i < en_q.size(); i++) begin
            checks++;
            if (en_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rmid_byte%0d got=%h required=%h", i, en_q[i], exp_q[i]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            uart_len = $urandom_range(0, 6);
            clear();
            send(w);
            wait_done(400, 1);
            uart_len = 0;
            model(w);
            checks++;
            if (en_q.size() != NB) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d required=%0d", k, en_q.size(), NB);
            end
            for (int i = 0; i < NB && i < en_q.size(); i++) begin
                checks++;
                if (en_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand%0d_byte%0d got=%h required=%h", k, i, en_q[i], exp_q[i]);
                end
            end
            checks++;
            if (busy_drop != 0) begin
                failures++;
                $display("FAIL rand%0d_busy_hold got=%0d required=0", k, busy_drop);
            end
            repeat (2) tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ideal();
        test_uart();
        test_busy_start();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
